// File: rtl/uouterprod_vvm_seq.sv
// Self-sequencing unary outer-product engine.
// Two sign-magnitude vectors are turned into Sobol-style bitstreams (bit-reversed
// counters). Each row stream gates a per-row counter that drives the column
// streams, so the AND of the two streams has popcount of about m0*m1/N.
// Every product bit moves a saturating signed accumulator by +1 or -1.
module uouterprod_vvm_seq #(
  parameter int ROWNUM      = 4,
  parameter int COLNUM      = 4,
  parameter int BITWIDTH    = 8,
  parameter int OUTBITWIDTH = 16
) (
  input  logic                                  iClk,
  input  logic                                  iRstN,
  input  logic                                  iClr,
  input  logic                                  iStart,
  input  logic                                  iAccum,
  input  logic [ROWNUM*BITWIDTH-1:0]            iData0,
  input  logic [COLNUM*BITWIDTH-1:0]            iData1,
  output logic                                  oBusy,
  output logic                                  oDone,
  output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0]  oData,
  output logic [ROWNUM*COLNUM-1:0]              oSat
);

  localparam int MW  = BITWIDTH - 1;
  localparam int NEL = ROWNUM * COLNUM;

  localparam logic [MW-1:0] CNT_ONE  = MW'(1);
  localparam logic [MW-1:0] CNT_LAST = '1;

  localparam logic signed [OUTBITWIDTH-1:0] ACC_ONE = OUTBITWIDTH'(1);
  localparam logic signed [OUTBITWIDTH-1:0] ACC_MAX = {1'b0, {(OUTBITWIDTH-1){1'b1}}};
  localparam logic signed [OUTBITWIDTH-1:0] ACC_MIN = {1'b1, {(OUTBITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT stateReg, stateNext;

  // Bit-reversal of a magnitude-width value: turns a linear counter into a
  // low-discrepancy threshold sequence.
  function automatic logic [MW-1:0] brev(input logic [MW-1:0] x);
    logic [MW-1:0] y;
    for (int k = 0; k < MW; k++) begin
      y[k] = x[MW-1-k];
    end
    return y;
  endfunction

  logic [ROWNUM*BITWIDTH-1:0] data0Reg;
  logic [COLNUM*BITWIDTH-1:0] data1Reg;
  logic [MW-1:0]              c0Reg;
  logic [MW-1:0]              r0;
  logic [MW-1:0]              c1Reg [ROWNUM];
  logic [MW-1:0]              r1    [ROWNUM];
  logic [MW-1:0]              m0    [ROWNUM];
  logic [MW-1:0]              m1    [COLNUM];
  logic [ROWNUM-1:0]          s0;
  logic [COLNUM-1:0]          s1;
  logic [ROWNUM-1:0]          b0;

  logic signed [OUTBITWIDTH-1:0] accReg [NEL];
  logic [NEL-1:0]                satReg;

  logic startAcc;
  logic runEn;

  // Accepted start and active run strobes; clear overrides both.
  always_comb begin
    startAcc = iStart & ~iClr & ((stateReg == IDLE) | (stateReg == DONE));
    runEn    = ~iClr & (stateReg == RUN);
  end

  // Run FSM state register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic: clear aborts, a run lasts until c0 wraps, DONE can restart directly.
  always_comb begin
    stateNext = stateReg;
    if (iClr) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE:    if (iStart) stateNext = RUN;
        RUN:     if (c0Reg == CNT_LAST) stateNext = DONE;
        DONE:    stateNext = iStart ? RUN : IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  assign oBusy = (stateReg == RUN);
  assign oDone = (stateReg == DONE);

  // Operand capture: the run only ever sees the copies taken at start.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      data0Reg <= '0;
      data1Reg <= '0;
    end else if (iClr) begin
      data0Reg <= '0;
      data1Reg <= '0;
    end else if (startAcc) begin
      data0Reg <= iData0;
      data1Reg <= iData1;
    end
  end

  // Row-stream counter; its last value (all ones) marks the final run cycle.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      c0Reg <= '0;
    end else if (iClr || startAcc) begin
      c0Reg <= '0;
    end else if (runEn) begin
      c0Reg <= c0Reg + CNT_ONE;
    end
  end

  assign r0 = brev(c0Reg);

  genvar gi, gj;

  generate
    for (gi = 0; gi < ROWNUM; gi++) begin : gRow
      assign m0[gi] = data0Reg[gi*BITWIDTH +: MW];
      assign s0[gi] = data0Reg[gi*BITWIDTH + MW];
      assign b0[gi] = (m0[gi] > r0);
      assign r1[gi] = brev(c1Reg[gi]);

      // Per-row column-stream counter advances only on row-stream ones.
      always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
          c1Reg[gi] <= '0;
        end else if (iClr || startAcc) begin
          c1Reg[gi] <= '0;
        end else if (runEn && b0[gi]) begin
          c1Reg[gi] <= c1Reg[gi] + CNT_ONE;
        end
      end
    end

    for (gj = 0; gj < COLNUM; gj++) begin : gCol
      assign m1[gj] = data1Reg[gj*BITWIDTH +: MW];
      assign s1[gj] = data1Reg[gj*BITWIDTH + MW];
    end

    for (gi = 0; gi < ROWNUM; gi++) begin : gElemRow
      for (gj = 0; gj < COLNUM; gj++) begin : gElemCol
        localparam int K = gi*COLNUM + gj;
        logic prod;
        logic sgn;

        assign prod = b0[gi] & (m1[gj] > r1[gi]);
        assign sgn  = s0[gi] ^ s1[gj];

        // Saturating up/down accumulator with sticky saturation flag.
        always_ff @(posedge iClk or negedge iRstN) begin
          if (!iRstN) begin
            accReg[K] <= '0;
            satReg[K] <= 1'b0;
          end else if (iClr) begin
            accReg[K] <= '0;
            satReg[K] <= 1'b0;
          end else if (startAcc) begin
            if (!iAccum) begin
              accReg[K] <= '0;
              satReg[K] <= 1'b0;
            end
          end else if (runEn && prod) begin
            if (sgn) begin
              if (accReg[K] == ACC_MIN) satReg[K] <= 1'b1;
              else                      accReg[K] <= accReg[K] - ACC_ONE;
            end else begin
              if (accReg[K] == ACC_MAX) satReg[K] <= 1'b1;
              else                      accReg[K] <= accReg[K] + ACC_ONE;
            end
          end
        end

        assign oData[K*OUTBITWIDTH +: OUTBITWIDTH] = accReg[K];
        assign oSat[K] = satReg[K];
      end
    end
  endgenerate

endmodule

// File: tb/tb_uouterprod_vvm_seq.sv
// Directed bench for uouterprod_vvm_seq: a 16-bit-accumulator instance for the
// main behaviour and an 8-bit-accumulator instance for saturation.
module tb_uouterprod_vvm_seq;

  localparam int NEL = 16;
  localparam int OW  = 16;
  localparam int OW8 = 8;

  logic clk = 1'b0;
  logic rstN;

  logic clr, start, accum;
  logic [31:0] d0, d1;
  logic busy, done;
  logic [NEL*OW-1:0] data;
  logic [NEL-1:0] sat;

  logic sClr, sStart, sAccum;
  logic [31:0] sD0, sD1;
  logic sBusy, sDone;
  logic [NEL*OW8-1:0] sData;
  logic [NEL-1:0] sSat;

  int nTests = 0;
  int nFail  = 0;

  logic signed [OW-1:0]  expv [NEL];
  logic signed [OW-1:0]  got;
  logic signed [OW8-1:0] got8;
  logic signed [OW-1:0]  colE [4];

  always #5 clk = ~clk;

  uouterprod_vvm_seq #(.ROWNUM(4), .COLNUM(4), .BITWIDTH(8), .OUTBITWIDTH(OW)) dut (
    .iClk(clk), .iRstN(rstN), .iClr(clr), .iStart(start), .iAccum(accum),
    .iData0(d0), .iData1(d1), .oBusy(busy), .oDone(done), .oData(data), .oSat(sat)
  );

  uouterprod_vvm_seq #(.ROWNUM(4), .COLNUM(4), .BITWIDTH(8), .OUTBITWIDTH(OW8)) dut8 (
    .iClk(clk), .iRstN(rstN), .iClr(sClr), .iStart(sStart), .iAccum(sAccum),
    .iData0(sD0), .iData1(sD1), .oBusy(sBusy), .oDone(sDone), .oData(sData), .oSat(sSat)
  );

  // Start a run on the main instance and wait (bounded) for oDone; returns at the done cycle.
  task automatic doRun(input logic acc, output bit ok, output int busyCnt);
    @(negedge clk);
    start = 1'b1;
    accum = acc;
    busyCnt = 0;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busyCnt++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Same for the 8-bit-accumulator instance.
  task automatic doRun8(input logic acc, output bit ok);
    @(negedge clk);
    sStart = 1'b1;
    sAccum = acc;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      sStart = 1'b0;
      if (sDone) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstN = 1'b0; clr = 1'b0; start = 1'b0; accum = 1'b0; d0 = '0; d1 = '0;
    sClr = 1'b0; sStart = 1'b0; sAccum = 1'b0; sD0 = '0; sD1 = '0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (10) @(negedge clk);
    nTests++; if (data !== '0) begin nFail++; $display("FAIL reset_data: got %h expected 0", data); end
    nTests++; if (sat !== '0) begin nFail++; $display("FAIL reset_sat: got %h expected 0", sat); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nTests++; if (done !== 1'b0) begin nFail++; $display("FAIL reset_done: got %b expected 0", done); end
    nTests++; if (sData !== '0) begin nFail++; $display("FAIL reset_data8: got %h expected 0", sData); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_timing;
    bit ok; int bc;
    d0 = {4{8'h40}}; d1 = {4{8'h40}};
    doRun(1'b0, ok, bc);
    nTests++; if (!ok) begin nFail++; $display("FAIL timing_done_timeout: got no oDone expected oDone"); end
    nTests++; if (bc != 128) begin nFail++; $display("FAIL timing_busy_cycles: got %0d expected 128", bc); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL timing_busy_in_done: got %b expected 0", busy); end
    @(negedge clk);
    nTests++; if (done !== 1'b0) begin nFail++; $display("FAIL timing_done_width: got %b expected 0", done); end
    for (int k = 0; k < NEL; k++) begin
      got = data[k*OW +: OW];
      nTests++; if (got !== 16'sd32) begin nFail++; $display("FAIL timing_elem%0d: got %0d expected 32", k, got); end
    end
    $display("[TB] test_timing busy=%0d", bc);
  endtask

  task automatic test_sign;
    bit ok; int bc;
    d0 = {8'h40, 8'h40, 8'h40, 8'hC0}; d1 = {4{8'h40}};
    doRun(1'b0, ok, bc);
    nTests++; if (!ok) begin nFail++; $display("FAIL sign_done_timeout: got no oDone expected oDone"); end
    for (int k = 0; k < NEL; k++) expv[k] = (k < 4) ? -16'sd32 : 16'sd32;
    for (int k = 0; k < NEL; k++) begin
      got = data[k*OW +: OW];
      nTests++; if (got !== expv[k]) begin nFail++; $display("FAIL sign_elem%0d: got %0d expected %0d", k, got, expv[k]); end
    end
    $display("[TB] test_sign done");
  endtask

  task automatic test_zero;
    bit ok; int bc;
    // rows: 0, -0, 127, 127; cols: 127, 5, -0, -5
    d0 = {8'h7F, 8'h7F, 8'h80, 8'h00}; d1 = {8'h85, 8'h80, 8'h05, 8'h7F};
    colE[0] = 16'sd127; colE[1] = 16'sd5; colE[2] = 16'sd0; colE[3] = -16'sd5;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        expv[i*4+j] = (i < 2) ? 16'sd0 : colE[j];
    doRun(1'b0, ok, bc);
    nTests++; if (!ok) begin nFail++; $display("FAIL zero_done_timeout: got no oDone expected oDone"); end
    for (int k = 0; k < NEL; k++) begin
      got = data[k*OW +: OW];
      nTests++; if (got !== expv[k]) begin nFail++; $display("FAIL zero_elem%0d: got %0d expected %0d", k, got, expv[k]); end
    end
    $display("[TB] test_zero done");
  endtask

  task automatic test_accum;
    bit ok; int bc; int nOk;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    nTests++; if (data !== '0) begin nFail++; $display("FAIL accum_clear: got %h expected 0", data); end
    d0 = {4{8'h40}}; d1 = {4{8'h40}};
    nOk = 0;
    for (int r = 0; r < 4; r++) begin
      doRun(1'b1, ok, bc);
      if (ok) nOk++;
    end
    nTests++; if (nOk != 4) begin nFail++; $display("FAIL accum_runs: got %0d completed expected 4", nOk); end
    for (int k = 0; k < NEL; k++) begin
      got = data[k*OW +: OW];
      nTests++; if (got !== 16'sd128) begin nFail++; $display("FAIL accum4_elem%0d: got %0d expected 128", k, got); end
    end
    nTests++; if (sat !== '0) begin nFail++; $display("FAIL accum_sat: got %h expected 0", sat); end
    doRun(1'b0, ok, bc);
    for (int k = 0; k < NEL; k++) begin
      got = data[k*OW +: OW];
      nTests++; if (got !== 16'sd32) begin nFail++; $display("FAIL accum_reset_elem%0d: got %0d expected 32", k, got); end
    end
    $display("[TB] test_accum done");
  endtask

  task automatic test_sat;
    bit ok;
    sD0 = {4{8'h7F}}; sD1 = {4{8'h7F}};
    doRun8(1'b0, ok);
    nTests++; if (!ok) begin nFail++; $display("FAIL sat_run1_timeout: got no oDone expected oDone"); end
    nTests++; if (sSat !== '0) begin nFail++; $display("FAIL sat_run1_flag: got %h expected 0", sSat); end
    doRun8(1'b1, ok);
    for (int k = 0; k < NEL; k++) begin
      got8 = sData[k*OW8 +: OW8];
      nTests++; if (got8 !== 8'sd127) begin nFail++; $display("FAIL sat_run2_elem%0d: got %0d expected 127", k, got8); end
    end
    nTests++; if (sSat !== 16'hFFFF) begin nFail++; $display("FAIL sat_run2_flag: got %h expected ffff", sSat); end
    sD1 = {4{8'hFF}};
    doRun8(1'b1, ok);
    for (int k = 0; k < NEL; k++) begin
      got8 = sData[k*OW8 +: OW8];
      nTests++; if (got8 !== 8'sd0) begin nFail++; $display("FAIL sat_neg_elem%0d: got %0d expected 0", k, got8); end
    end
    nTests++; if (sSat !== 16'hFFFF) begin nFail++; $display("FAIL sat_sticky: got %h expected ffff", sSat); end
    $display("[TB] test_sat done");
  endtask

  task automatic test_clear;
    int seen;
    d0 = {4{8'h40}}; d1 = {4{8'h40}};
    @(negedge clk); start = 1'b1; accum = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (39) @(negedge clk);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL clear_busy: got %b expected 0", busy); end
    nTests++; if (done !== 1'b0) begin nFail++; $display("FAIL clear_done: got %b expected 0", done); end
    nTests++; if (data !== '0) begin nFail++; $display("FAIL clear_data: got %h expected 0", data); end
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    nTests++; if (seen != 0) begin nFail++; $display("FAIL clear_no_done: got %0d active cycles expected 0", seen); end
    $display("[TB] test_clear done");
  endtask

  task automatic test_async_reset;
    bit ok; int bc;
    d0 = {4{8'h40}}; d1 = {4{8'h40}};
    @(negedge clk); start = 1'b1; accum = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    nTests++; if (data !== '0) begin nFail++; $display("FAIL areset_data: got %h expected 0", data); end
    nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL areset_busy: got %b expected 0", busy); end
    @(negedge clk); rstN = 1'b1;
    doRun(1'b0, ok, bc);
    nTests++; if (bc != 128) begin nFail++; $display("FAIL areset_rerun_busy: got %0d expected 128", bc); end
    got = data[0 +: OW];
    nTests++; if (got !== 16'sd32) begin nFail++; $display("FAIL areset_rerun_elem0: got %0d expected 32", got); end
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_midrun;
    bit ok; int bc;
    d0 = {4{8'h40}}; d1 = {4{8'h40}};
    @(negedge clk); start = 1'b1; accum = 1'b0;
    bc = 0; ok = 1'b0;
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
      if (done) begin ok = 1'b1; break; end
      if (k == 20) begin d0 = {4{8'h7F}}; d1 = {4{8'h85}}; start = 1'b1; accum = 1'b1; end
      if (k == 60) begin start = 1'b1; accum = 1'b0; end
    end
    nTests++; if (!ok) begin nFail++; $display("FAIL midrun_timeout: got no oDone expected oDone"); end
    nTests++; if (bc != 128) begin nFail++; $display("FAIL midrun_busy: got %0d expected 128", bc); end
    for (int k = 0; k < NEL; k++) begin
      got = data[k*OW +: OW];
      nTests++; if (got !== 16'sd32) begin nFail++; $display("FAIL midrun_elem%0d: got %0d expected 32", k, got); end
    end
    $display("[TB] test_midrun done");
  endtask

  task automatic test_back_to_back;
    bit ok; int bc;
    d0 = {4{8'h40}}; d1 = {4{8'h40}};
    doRun(1'b0, ok, bc);
    start = 1'b1; accum = 1'b1;
    @(negedge clk); start = 1'b0;
    nTests++; if (busy !== 1'b1) begin nFail++; $display("FAIL b2b_no_gap: got %b expected 1", busy); end
    bc = 1; ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin ok = 1'b1; break; end
    end
    nTests++; if (!ok) begin nFail++; $display("FAIL b2b_timeout: got no oDone expected oDone"); end
    nTests++; if (bc != 128) begin nFail++; $display("FAIL b2b_busy: got %0d expected 128", bc); end
    for (int k = 0; k < NEL; k++) begin
      got = data[k*OW +: OW];
      nTests++; if (got !== 16'sd64) begin nFail++; $display("FAIL b2b_elem%0d: got %0d expected 64", k, got); end
    end
    $display("[TB] test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_timing();
    test_sign();
    test_zero();
    test_accum();
    test_sat();
    test_clear();
    test_async_reset();
    test_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
